calc1_port_responder: RTL and testbench
=======================================

Name: calc1_port_responder

Overview:
Single-port command responder for the calc1 request/response protocol. It owns the port side that answers requesters: it captures a command and two operands, executes add, subtract, shift-left or shift-right, and returns one response beat. Four instances, one per port, form the calc1 datapath. It also serves as the golden reference model that the port benches compare against.

Parameters:
LATENCY, 1, number of execute cycles between operand-2 capture and response (legal 1..15)
DROP_W, 8, width of the saturating dropped-command counter

Ports:
c_clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
req_cmd_in  input  [0:3]  command: 0 no-op, 1 add, 2 sub, 5 shl, 6 shr; all other values are invalid
req_data_in  input  [0:31]  operand 1 in the command cycle, operand 2 in the following cycle; bit 0 is the MSB
out_resp  output  [0:1]  0 none, 1 success, 2 overflow/underflow/invalid command, 3 unused
out_data  output  [0:31]  result; valid only while out_resp is nonzero, otherwise 0
busy  output  1  high whenever the state is not IDLE
drop_count  output  [0:DROP_W-1]  count of nonzero commands ignored while busy; saturates at all-ones

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; out_resp=0, out_data=0, busy=0, drop_count=0. Internal operand, command and latency-counter registers are cleared.
- All outputs are registered.
- Asserting reset mid-operation aborts the transaction with no response. The first command is accepted at the first edge after reset deasserts.
- States:
  - IDLE: nonzero legal cmd at edge n latches cmd and operand 1 -> OP2. Invalid cmd (3, 4, 7..15) -> RESP with resp=2, data=0; no operand 2 is consumed, so the response is visible after edge n+1. cmd=0 stays IDLE.
  - OP2: next edge latches req_data_in as operand 2 -> EXEC and loads the counter with LATENCY-1. req_cmd_in in this cycle must be 0; a nonzero value is ignored and counted as a drop.
  - EXEC: counter decrements each edge. When it reaches 0, compute and -> RESP.
  - RESP: out_resp/out_data are driven for exactly one cycle, then -> IDLE. A nonzero cmd during RESP is dropped, not accepted. The next accept is possible one cycle after the response.
- With LATENCY=1, operand 2 is sampled at edge m, the response is visible after edge m+2 and cleared after edge m+3.
- Arithmetic, all unsigned 32-bit:
  - add: 33-bit sum. A carry out gives resp=2, data=0; otherwise resp=1 with the sum.
  - sub: operand 2 > operand 1 gives resp=2, data=0; equal operands give resp=1, data=0; otherwise resp=1 with the difference.
  - shl/shr: shift amount is operand2[27:31] (low 5 bits, 0..31), zero fill; always resp=1. Bits shifted out are lost and are not an error.
- Drops: each cycle with busy=1 and a nonzero cmd increments drop_count by 1 unless it is already saturated. Drops never alter the in-flight operation.
- A simultaneous drop and response in the same cycle are both handled: the response is emitted and the counter increments.

Test Plan:
- Reset held 4 cycles, then released -> all outputs 0, busy=0. A reset pulse during EXEC of an add -> no response, drop_count=0, IDLE.
- add: 0x00000001 + 0x01FFFFFF -> resp=1, data=0x02000000, 2 cycles after operand 2. 0x1FFFFFFF + 0x1FFFFFFF -> 0x3FFFFFFE. 0+0 -> resp=1, data=0.
- Boundaries: add 0xFFFFFFFF + 1 -> resp=2, data=0. sub 1 - 0xF -> resp=2, data=0. sub 5 - 5 -> resp=1, data=0.
- Shifts: shl 0x00000001 by 1 -> 0x00000002. Walking shl 1<<k by 1 for k=0..30 -> 1<<(k+1). shr 0x80000000 by 31 -> 0x00000001. shl 0xFFFFFFFF by 32 (amount field 0) -> 0xFFFFFFFF.
- Invalid cmd 3, then cmd 4, each with data=1 -> resp=2, data=0, one cycle after the command. The next legal add is accepted normally.
- Busy drops: cmd=1 issued in the OP2, EXEC and RESP cycles of an add with LATENCY=3 -> original result unchanged, drop_count=3. 300 drops with DROP_W=8 -> drop_count=255.

Source files
------------

// File: rtl/calc1_port_responder_if.sv
// Request/response bundle for one calc1 port.
// The master drives commands and operands. The slave (the responder) returns results and status.
interface calc1_port_responder_if #(
    parameter int DROP_W = 8
);
    logic [0:3]        req_cmd_in;
    logic [0:31]       req_data_in;
    logic [0:1]        out_resp;
    logic [0:31]       out_data;
    logic              busy;
    logic [0:DROP_W-1] drop_count;

    modport master (
        output req_cmd_in, req_data_in,
        input  out_resp, out_data, busy, drop_count
    );

    modport slave (
        input  req_cmd_in, req_data_in,
        output out_resp, out_data, busy, drop_count
    );
endinterface

// File: rtl/calc1_port_responder.sv
// Single-port calc1 responder: captures a command and two operands, executes add/sub/shl/shr,
// and returns a single one-cycle response beat. Commands that arrive while busy are counted as drops.
module calc1_port_responder #(
    parameter int LATENCY = 1,
    parameter int DROP_W  = 8
) (
    input logic                   c_clk,
    input logic                   reset,
    calc1_port_responder_if.slave port_if
);
    typedef enum logic [1:0] {S_IDLE, S_OP2, S_EXEC, S_RESP} state_e;

    localparam logic [3:0]        LAT_LOAD = 4'(LATENCY - 1);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    state_e            state_q;
    logic [3:0]        cmd_q;
    logic [3:0]        cnt_q;
    logic [31:0]       op1_q;
    logic [31:0]       op2_q;
    logic [1:0]        resp_q;
    logic [31:0]       data_q;
    logic              busy_q;
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W-1:0] drop_d;
    logic [3:0]        cmd_in;
    logic [31:0]       din;

    assign cmd_in = port_if.req_cmd_in;
    assign din    = port_if.req_data_in;

    function automatic logic cmd_legal(input logic [3:0] c);
        return c inside {4'd1, 4'd2, 4'd5, 4'd6};
    endfunction

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + DROP_W'(1);
    endfunction

    // Returns {resp, data}. Any error code always carries a zero result.
    function automatic logic [33:0] execute(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        case (c)
            4'd1:    return sum[32] ? {2'd2, 32'd0} : {2'd1, sum[31:0]};
            4'd2:    return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
            4'd5:    return {2'd1, a << b[4:0]};
            4'd6:    return {2'd1, a >> b[4:0]};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    always_comb begin
        drop_d = drop_q;
        if (state_q != S_IDLE && cmd_in != 4'd0) drop_d = sat_inc(drop_q);
    end

    // The response is formed on the RESP edge, so it becomes visible in the cycle after RESP.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            resp_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            drop_q <= drop_d;
            resp_q <= 2'd0;
            data_q <= 32'd0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_in != 4'd0) begin
                        cmd_q   <= cmd_in;
                        op1_q   <= din;
                        state_q <= cmd_legal(cmd_in) ? S_OP2 : S_RESP;
                        busy_q  <= 1'b1;
                    end
                end
                S_OP2: begin
                    op2_q   <= din;
                    cnt_q   <= LAT_LOAD;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (cnt_q == 4'd0) state_q <= S_RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                S_RESP: begin
                    {resp_q, data_q} <= execute(cmd_q, op1_q, op2_q);
                    state_q          <= S_IDLE;
                    busy_q           <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign port_if.out_resp   = resp_q;
    assign port_if.out_data   = data_q;
    assign port_if.busy       = busy_q;
    assign port_if.drop_count = drop_q;
endmodule

// File: tb/tb_calc1_port_responder.sv
// Bench for calc1_port_responder. It uses two instances: LATENCY=1 (sel 0) and LATENCY=3 (sel 1).
// Results are checked against an arithmetic reference model and a cycle-count timing model.
module tb_calc1_port_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc1_port_responder_if #(.DROP_W(8)) if1 ();
    calc1_port_responder_if #(.DROP_W(8)) if3 ();

    calc1_port_responder #(.LATENCY(1), .DROP_W(8)) dut1 (.c_clk(clk), .reset(rst_n), .port_if(if1));
    calc1_port_responder #(.LATENCY(3), .DROP_W(8)) dut3 (.c_clk(clk), .reset(rst_n), .port_if(if3));

    int          sel_r = 0;
    logic [3:0]  cmd_r = 4'd0;
    logic [31:0] din_r = 32'd0;
    int          vectors = 0;
    int          miscompares = 0;
    int          exp_drop[2] = '{0, 0};

    assign if1.req_cmd_in  = (sel_r == 0) ? cmd_r : 4'd0;
    assign if1.req_data_in = din_r;
    assign if3.req_cmd_in  = (sel_r == 1) ? cmd_r : 4'd0;
    assign if3.req_data_in = din_r;

    logic [1:0]  o_resp;
    logic [31:0] o_data;
    logic        o_busy;
    logic [7:0]  o_drop;
    assign o_resp = (sel_r == 1) ? if3.out_resp   : if1.out_resp;
    assign o_data = (sel_r == 1) ? if3.out_data   : if1.out_data;
    assign o_busy = (sel_r == 1) ? if3.busy       : if1.busy;
    assign o_drop = (sel_r == 1) ? if3.drop_count : if1.drop_count;

    // Reference model: plain 64-bit arithmetic. Returns {resp, data}.
    function automatic logic [33:0] ref_model(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] s;
        int sh;
        sh = int'(b % 32);
        case (c)
            4'd1: begin
                s = 64'(a) + 64'(b);
                if (s > 64'hFFFF_FFFF) return {2'd2, 32'd0};
                return {2'd1, s[31:0]};
            end
            4'd2: begin
                if (b > a) return {2'd2, 32'd0};
                s = 64'(a) - 64'(b);
                return {2'd1, s[31:0]};
            end
            4'd5: begin
                s = 64'(a) << sh;
                return {2'd1, s[31:0]};
            end
            4'd6: begin
                s = 64'(a) >> sh;
                return {2'd1, s[31:0]};
            end
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    function automatic bit is_legal(input logic [3:0] c);
        return (c == 4'd1 || c == 4'd2 || c == 4'd5 || c == 4'd6);
    endfunction

    // One transaction. Mask bit i drives cmd=1 in the cycle after edge i, counted from the command edge.
    task automatic do_op(input int sel, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] mask, input string tag);
        logic [33:0] exp;
        int lat, k_exp, k, n_drop;
        bit got;
        logic [1:0] r;
        logic [31:0] d;
        lat   = (sel == 1) ? 3 : 1;
        k_exp = is_legal(c) ? lat + 3 : 2;
        exp   = ref_model(c, a, b);
        n_drop = 0;
        for (int i = 1; i < k_exp; i++) if (mask[i]) n_drop++;
        exp_drop[sel] = (exp_drop[sel] + n_drop > 255) ? 255 : exp_drop[sel] + n_drop;

        @(negedge clk);
        sel_r = sel;
        cmd_r = c;
        din_r = a;
        got = 1'b0; k = 0; r = 2'd0; d = 32'd0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (i == 1) begin
                vectors++;
                if (o_busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s busy_after_accept: got %b want 1", tag, o_busy);
                end
            end
            if (o_resp !== 2'd0) begin
                got = 1'b1; k = i; r = o_resp; d = o_data;
                vectors++;
                if (o_busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s busy_at_resp: got %b want 0", tag, o_busy);
                end
                cmd_r = 4'd0;
            end else begin
                cmd_r = mask[i] ? 4'd1 : 4'd0;
                if (i == 1) din_r = b;
            end
        end
        cmd_r = 4'd0;

        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s timeout: no response within 40 cycles, want one after %0d", tag, k_exp);
        end else begin
            if (k != k_exp) begin
                miscompares++;
                $display("FAIL %s latency: got %0d edges want %0d", tag, k, k_exp);
            end
            vectors++;
            if (r !== exp[33:32]) begin
                miscompares++;
                $display("FAIL %s resp: got %0d want %0d", tag, r, exp[33:32]);
            end
            vectors++;
            if (d !== exp[31:0]) begin
                miscompares++;
                $display("FAIL %s data: got %h want %h", tag, d, exp[31:0]);
            end
            @(negedge clk);
            vectors++;
            if (o_resp !== 2'd0 || o_data !== 32'd0) begin
                miscompares++;
                $display("FAIL %s resp_cleared: got %0d/%h want 0/0", tag, o_resp, o_data);
            end
        end
        vectors++;
        if (o_drop !== 8'(exp_drop[sel])) begin
            miscompares++;
            $display("FAIL %s drop_count: got %0d want %0d", tag, o_drop, exp_drop[sel]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (if1.out_resp !== 2'd0 || if1.out_data !== 32'd0 || if1.busy !== 1'b0 ||
            if1.drop_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_dut1: resp %0d data %h busy %b drop %0d want all 0",
                     if1.out_resp, if1.out_data, if1.busy, if1.drop_count);
        end
        vectors++;
        if (if3.out_resp !== 2'd0 || if3.busy !== 1'b0 || if3.drop_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_dut3: resp %0d busy %b drop %0d want all 0",
                     if3.out_resp, if3.busy, if3.drop_count);
        end
        rst_n = 1'b1;
        exp_drop[0] = 0;
        exp_drop[1] = 0;
    endtask

    task automatic test_add();
        do_op(0, 4'd1, 32'h0000_0001, 32'h01FF_FFFF, 16'h0, "add_small");
        do_op(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 16'h0, "add_mid");
        do_op(0, 4'd1, 32'h0, 32'h0, 16'h0, "add_zero");
        do_op(0, 4'd1, 32'hFFFF_FFFF, 32'h1, 16'h0, "add_carry");
    endtask

    task automatic test_sub();
        do_op(0, 4'd2, 32'h1, 32'hF, 16'h0, "sub_under");
        do_op(0, 4'd2, 32'h5, 32'h5, 16'h0, "sub_equal");
        do_op(0, 4'd2, 32'h9000_0000, 32'h1234_5678, 16'h0, "sub_normal");
    endtask

    task automatic test_shift();
        do_op(0, 4'd5, 32'h1, 32'h1, 16'h0, "shl_1");
        for (int k = 0; k <= 30; k++) do_op(0, 4'd5, 32'h1 << k, 32'h1, 16'h0, "shl_walk");
        do_op(0, 4'd6, 32'h8000_0000, 32'd31, 16'h0, "shr_31");
        do_op(0, 4'd5, 32'hFFFF_FFFF, 32'd32, 16'h0, "shl_32");
    endtask

    task automatic test_invalid();
        do_op(0, 4'd3, 32'h1, 32'h0, 16'h0, "invalid_3");
        do_op(0, 4'd4, 32'h1, 32'h0, 16'h0, "invalid_4");
        do_op(0, 4'd1, 32'h10, 32'h20, 16'h0, "add_after_invalid");
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic [31:0] a, b;
        for (int n = 0; n < 40; n++) begin
            c = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 2) != 0) c = (n % 2 == 0) ? 4'd1 : 4'd2;
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? (~a + 32'($urandom_range(0, 2))) : $urandom();
            do_op(0, c, a, b, 16'h0, "random");
        end
    endtask

    task automatic test_busy_drops();
        do_op(1, 4'd1, 32'h0000_1234, 32'h0000_0001, 16'b0000_0000_0010_1010, "drop_3");
    endtask

    task automatic test_drop_saturation();
        logic [3:0] legal[4] = '{4'd1, 4'd2, 4'd5, 4'd6};
        for (int n = 0; n < 60; n++)
            do_op(1, legal[$urandom_range(0, 3)], $urandom(), $urandom(),
                  16'b0000_0000_0011_1110, "drop_sat");
    endtask

    task automatic test_reset_mid_exec();
        bit seen;
        @(negedge clk);
        sel_r = 1; cmd_r = 4'd1; din_r = 32'h5;
        @(negedge clk);
        cmd_r = 4'd0; din_r = 32'h6;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_drop[0] = 0;
        exp_drop[1] = 0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if3.out_resp !== 2'd0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL reset_abort_resp: got a response want none");
        end
        vectors++;
        if (if3.busy !== 1'b0 || if3.drop_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_abort_state: busy %b drop %0d want 0/0", if3.busy, if3.drop_count);
        end
        do_op(1, 4'd1, 32'h7, 32'h8, 16'h0, "add_after_abort");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_invalid();
        test_random();
        test_busy_drops();
        test_drop_saturation();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
